skein_ubi_ctrl: RTL

- UBI chaining controller that sits directly upstream of the Skein-1024 block-process core.
- Accepts 1024-bit message blocks with first/last markers and a byte count.
- Builds the 17-word extended key (chaining value plus parity word) and the 192-bit tweak (t0, t1, t2 = t0^t1), then launches the core.
- Applies the UBI feed-forward (core output XOR message) to form the next chaining value, and presents the final chaining value on the last block.

---
 rtl/skein_ubi_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/skein_ubi_ctrl.sv
// UBI chaining controller for a Skein-1024 block core: builds key and tweak,
// launches the core, applies feed-forward and reports the final chaining value.
module skein_ubi_ctrl #(
  parameter logic [63:0] KS_PARITY = 64'h1BD11BDAA9FC1A22,
  parameter logic [5:0]  TYPE_CODE = 6'd48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [1023:0] msg_block,
  input  logic [7:0]    msg_bytes,
  input  logic          msg_first,
  input  logic          msg_last,
  input  logic [1023:0] cv_init,
  output logic          blk_start,
  output logic [1023:0] blk_in,
  output logic [1087:0] blk_key,
  output logic [191:0]  blk_type,
  input  logic          blk_done,
  input  logic [1023:0] blk_out,
  output logic [1023:0] cv_out,
  output logic          cv_valid,
  output logic [1:0]    dbg_state
);

  // Handshake: a block is accepted on a rising edge where msg_valid && msg_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, FEED = 2'd3} state_t;

  state_t          state_q;
  logic            msg_ready_q, blk_start_q, cv_valid_q;
  logic [1023:0]   blk_in_q, cv_q, cv_out_q;
  logic [1087:0]   blk_key_q;
  logic [191:0]    blk_type_q;
  logic [95:0]     pos_q;
  logic            last_q, seen_low_q;

  logic [7:0]      bytes_eff;
  logic [95:0]     pos_d;
  logic [1023:0]   key_src;
  logic [63:0]     parity;
  logic [63:0]     t0_d, t1_d;
  logic [1023:0]   feed;

  always_comb begin
    bytes_eff = (msg_bytes > 8'd128) ? 8'd128 : msg_bytes;
    pos_d     = (msg_first ? 96'd0 : pos_q) + {88'd0, bytes_eff};
    key_src   = msg_first ? cv_init : cv_q;
    parity    = KS_PARITY;
    for (int i = 0; i < 16; i++) parity = parity ^ key_src[64*i +: 64];
    t0_d      = pos_d[63:0];
    t1_d      = {msg_last, msg_first, TYPE_CODE, 24'd0, pos_d[95:64]};
    feed      = blk_out ^ blk_in_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      msg_ready_q <= 1'b1;
      blk_start_q <= 1'b0;
      cv_valid_q  <= 1'b0;
      blk_in_q    <= '0;
      blk_key_q   <= '0;
      blk_type_q  <= '0;
      cv_out_q    <= '0;
      cv_q        <= '0;
      pos_q       <= '0;
      last_q      <= 1'b0;
      seen_low_q  <= 1'b0;
    end else begin
      blk_start_q <= 1'b0;
      cv_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (msg_valid) begin
            // Key and tweak are built here so they are already stable while blk_start is high.
            blk_in_q    <= msg_block;
            blk_key_q   <= {parity, key_src};
            blk_type_q  <= {t0_d ^ t1_d, t1_d, t0_d};
            pos_q       <= pos_d;
            last_q      <= msg_last;
            blk_start_q <= 1'b1;
            msg_ready_q <= 1'b0;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          // A low done at the launch edge already proves the level is not stale.
          seen_low_q <= ~blk_done;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (seen_low_q && blk_done) state_q <= FEED;
          else if (!blk_done)         seen_low_q <= 1'b1;
        end
        FEED: begin
          cv_q <= feed;
          if (last_q) begin
            cv_out_q   <= feed;
            cv_valid_q <= 1'b1;
          end
          msg_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign msg_ready = msg_ready_q;
  assign blk_start = blk_start_q;
  assign blk_in    = blk_in_q;
  assign blk_key   = blk_key_q;
  assign blk_type  = blk_type_q;
  assign cv_out    = cv_out_q;
  assign cv_valid  = cv_valid_q;
  assign dbg_state = state_q;

endmodule
